// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, register zero and
// the NOP that flushed pipeline registers represent.
package pipe_ctrl_pkg;

  localparam logic [1:0] CTRL_RUN   = 2'd0;
  localparam logic [1:0] CTRL_FLUSH = 2'd1;
  localparam logic [1:0] CTRL_HOLD  = 2'd2;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  // addi x0, x0, 0 -- what a flushed IF/ID or ID/EX register stands for
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic src_hit(input logic used, input logic [4:0] src,
                                   input logic [4:0] rd);
    return used && (src == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
// Purely combinational so the forwarding unit can share it.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd_addr,
  output logic       load_use
);

  always_comb begin
    load_use = ex_is_load && (ex_rd_addr != REG_ZERO) &&
               (src_hit(rs1_used, rs1_addr, ex_rd_addr) ||
                src_hit(rs2_used, rs2_addr, ex_rd_addr));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline sequencer: load-use stalls, jump redirect/flush,
// multi-cycle hold with timeout flag, and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned HOLD_TIMEOUT = 1023,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic             i_ex_is_load,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_jump_en,
  input  logic [31:0]      i_ex_jump_addr,
  input  logic             i_hold_req,
  output logic             o_hold_ack,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_idex_stall,
  output logic             o_exmem_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_pc_jump_en,
  output logic [31:0]      o_pc_jump_addr,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_hold_err
);

  localparam int unsigned HCNT_W    = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [3:0]  FCNT_INIT = 4'(FLUSH_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              hold_err_q, hold_err_d;
  logic              load_use;

  pipe_ctrl_hazard_detect u_hazard_detect (
    .rs1_addr   (i_id_rs1_addr),
    .rs2_addr   (i_id_rs2_addr),
    .rs1_used   (i_id_rs1_used),
    .rs2_used   (i_id_rs2_used),
    .ex_is_load (i_ex_is_load),
    .ex_rd_addr (i_ex_rd_addr),
    .load_use   (load_use)
  );

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    hcnt_d         = '0;
    hold_err_d     = hold_err_q;
    o_hold_ack     = 1'b0;
    o_pc_stall     = 1'b0;
    o_ifid_stall   = 1'b0;
    o_idex_stall   = 1'b0;
    o_exmem_stall  = 1'b0;
    o_ifid_flush   = 1'b0;
    o_idex_flush   = 1'b0;
    o_pc_jump_en   = 1'b0;
    o_pc_jump_addr = 32'd0;

    if (i_rst) begin
      case (state_q)
        CTRL_RUN: begin
          if (i_ex_jump_en) begin
            o_pc_jump_en   = 1'b1;
            o_pc_jump_addr = i_ex_jump_addr;
            o_ifid_flush   = 1'b1;
            o_idex_flush   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = CTRL_FLUSH;
              fcnt_d  = FCNT_INIT;
            end else if (i_hold_req) begin
              state_d = CTRL_HOLD;
            end
          end else if (load_use) begin
            // Single bubble: the load moves to MEM next cycle and forwarding takes over.
            o_pc_stall   = 1'b1;
            o_ifid_stall = 1'b1;
            o_idex_flush = 1'b1;
          end else if (i_hold_req) begin
            state_d = CTRL_HOLD;
          end
        end
        CTRL_FLUSH: begin
          o_ifid_flush = 1'b1;
          o_idex_flush = 1'b1;
          fcnt_d       = fcnt_q - 4'd1;
          if (fcnt_q <= 4'd1) begin
            state_d = i_hold_req ? CTRL_HOLD : CTRL_RUN;
          end
        end
        CTRL_HOLD: begin
          o_hold_ack    = 1'b1;
          o_pc_stall    = 1'b1;
          o_ifid_stall  = 1'b1;
          o_idex_stall  = 1'b1;
          o_exmem_stall = 1'b1;
          hcnt_d        = (hcnt_q != HCNT_W'(HOLD_TIMEOUT)) ? hcnt_q + 1'b1 : hcnt_q;
          if (32'(hcnt_q) + 32'd1 >= HOLD_TIMEOUT) begin
            hold_err_d = 1'b1;
          end
          if (!i_hold_req) begin
            state_d = CTRL_RUN;
          end
        end
        default: state_d = CTRL_RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= CTRL_RUN;
      fcnt_q      <= '0;
      hcnt_q      <= '0;
      stall_cnt_q <= '0;
      hold_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      hcnt_q      <= hcnt_d;
      stall_cnt_q <= stall_cnt_d;
      hold_err_q  <= hold_err_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_hold_err  = hold_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table, hand-written multi-cycle sequences and
// randomized stimulus against a behavioural reference model.
module tb_pipe_ctrl;

  localparam int unsigned FC = 2;
  localparam int unsigned HT = 2;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic        hold_ack;
    logic        pc_stall;
    logic        ifid_stall;
    logic        idex_stall;
    logic        exmem_stall;
    logic        ifid_flush;
    logic        idex_flush;
    logic        pc_jump_en;
    logic [31:0] pc_jump_addr;
  } comb_t;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        ld;
    logic [4:0]  rd;
    logic        jmp;
    logic [31:0] addr;
    comb_t       exp;
  } vec_t;

  localparam comb_t C_IDLE  = '0;
  localparam comb_t C_LU    = {8'b0110_0010, 32'h0};
  localparam comb_t C_HOLD  = {8'b1111_1000, 32'h0};
  localparam comb_t C_FLUSH = {8'b0000_0110, 32'h0};

  function automatic comb_t c_jump(input logic [31:0] a);
    return {8'b0000_0111, a};
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1, rs2, rd;
  logic          u1, u2, ld, jmp, hreq;
  logic [31:0]   jaddr;
  logic          hold_ack, pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic          ifid_flush, idex_flush, pc_jump_en, hold_err;
  logic [31:0]   pc_jump_addr;
  logic [CW-1:0] stall_cnt;
  comb_t         act;

  int n_checks;
  int n_errors;

  // Reference model state
  int   m_flush_left;
  bit   m_holding;
  int   m_hold_len;
  bit   m_err;
  int   m_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .FLUSH_CYCLES (FC),
    .HOLD_TIMEOUT (HT),
    .CNT_W        (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_id_rs1_addr  (rs1),
    .i_id_rs2_addr  (rs2),
    .i_id_rs1_used  (u1),
    .i_id_rs2_used  (u2),
    .i_ex_is_load   (ld),
    .i_ex_rd_addr   (rd),
    .i_ex_jump_en   (jmp),
    .i_ex_jump_addr (jaddr),
    .i_hold_req     (hreq),
    .o_hold_ack     (hold_ack),
    .o_pc_stall     (pc_stall),
    .o_ifid_stall   (ifid_stall),
    .o_idex_stall   (idex_stall),
    .o_exmem_stall  (exmem_stall),
    .o_ifid_flush   (ifid_flush),
    .o_idex_flush   (idex_flush),
    .o_pc_jump_en   (pc_jump_en),
    .o_pc_jump_addr (pc_jump_addr),
    .o_stall_cnt    (stall_cnt),
    .o_hold_err     (hold_err)
  );

  always_comb begin
    act = {hold_ack, pc_stall, ifid_stall, idex_stall, exmem_stall,
           ifid_flush, idex_flush, pc_jump_en, pc_jump_addr};
  end

  task automatic check_comb(input string name, input comb_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Apply one cycle of inputs away from the rising edge, then settle.
  task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic e1, input logic e2, input logic l, input logic [4:0] d,
                       input logic j, input logic [31:0] ja, input logic hr);
    @(negedge clk);
    rst = r; rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; ld = l; rd = d;
    jmp = j; jaddr = ja; hreq = hr;
    #2;
  endtask

  task automatic idle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic hold_cyc(input logic hr, input logic j, input logic [31:0] ja);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, j, ja, hr);
  endtask

  function automatic comb_t m_expect();
    comb_t e;
    logic  lu;
    e  = '0;
    lu = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (!rst)                  e = '0;
    else if (m_holding)        e = C_HOLD;
    else if (m_flush_left > 0) e = C_FLUSH;
    else if (jmp)              e = c_jump(jaddr);
    else if (lu)               e = C_LU;
    return e;
  endfunction

  task automatic m_step();
    comb_t e;
    logic  lu;
    e  = m_expect();
    lu = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (!rst) begin
      m_flush_left = 0; m_holding = 0; m_hold_len = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (e.pc_stall && m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_holding) begin
        m_hold_len++;
        if (m_hold_len >= HT) m_err = 1;
        if (!hreq) m_holding = 0;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
        if (m_flush_left == 0 && hreq) begin m_holding = 1; m_hold_len = 0; end
      end else if (jmp) begin
        if (FC > 1) m_flush_left = FC - 1;
        else if (hreq) begin m_holding = 1; m_hold_len = 0; end
      end else if (!lu && hreq) begin
        m_holding = 1; m_hold_len = 0;
      end
    end
  endtask

  initial begin
    vec_t vt[10];
    logic hr_prev;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; rs1 = '0; rs2 = '0; u1 = 0; u2 = 0; ld = 0; rd = '0;
    jmp = 0; jaddr = '0; hreq = 0;

    // Reset state
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 32'h44, 1'b1);
    check_comb("reset_comb", C_IDLE);
    check_val("reset_cnt", 32'(stall_cnt), 0);
    check_val("reset_err", 32'(hold_err), 0);

    // Single-cycle behaviour from RUN; each vector is followed by two idle cycles
    vt[0] = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 32'h0,        C_LU};
    vt[1] = '{5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 32'h0,        C_IDLE};
    vt[2] = '{5'd1,  5'd7,  1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 32'h0,        C_IDLE};
    vt[3] = '{5'd1,  5'd7,  1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 32'h0,        C_LU};
    vt[4] = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 5'd5,  1'b0, 32'h0,        C_IDLE};
    vt[5] = '{5'd30, 5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 32'h0,        C_LU};
    vt[6] = '{5'd9,  5'd9,  1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 32'h0,        C_IDLE};
    vt[7] = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b1, 32'h100,      c_jump(32'h100)};
    vt[8] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 32'hDEADBEEC, c_jump(32'hDEADBEEC)};
    vt[9] = '{5'd4,  5'd5,  1'b1, 1'b1, 1'b1, 5'd3,  1'b0, 32'h0,        C_IDLE};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vt[i].rs1, vt[i].rs2, vt[i].u1, vt[i].u2, vt[i].ld, vt[i].rd,
            vt[i].jmp, vt[i].addr, 1'b0);
      check_comb($sformatf("vec%0d", i), vt[i].exp);
      idle();
      idle();
    end
    check_val("table_cnt", 32'(stall_cnt), 3);

    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);

    // Load-use for one cycle
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 32'd0, 1'b0);
    check_comb("lu_cycle", C_LU);
    check_val("lu_cnt_before", 32'(stall_cnt), 0);
    idle();
    check_comb("lu_after", C_IDLE);
    check_val("lu_cnt_after", 32'(stall_cnt), 1);

    // Jump with two flush cycles; jump/load-use in FLUSH are ignored
    hold_cyc(1'b0, 1'b1, 32'h0000_0100);
    check_comb("jmp_t0", c_jump(32'h100));
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 32'h200, 1'b0);
    check_comb("jmp_t1", C_FLUSH);
    idle();
    check_comb("jmp_t2", C_IDLE);

    // Jump beats load-use
    drive(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 32'h40, 1'b0);
    check_comb("jmp_lu", c_jump(32'h40));
    idle();
    check_comb("jmp_lu_flush", C_FLUSH);
    idle();
    check_val("jmp_lu_cnt", 32'(stall_cnt), 1);

    // Hold for three cycles with a pending jump taken after release
    hold_cyc(1'b1, 1'b0, 32'h0);
    check_comb("hold_t0", C_IDLE);
    hold_cyc(1'b1, 1'b1, 32'h80);
    check_comb("hold_t1", C_HOLD);
    hold_cyc(1'b1, 1'b1, 32'h80);
    check_comb("hold_t2", C_HOLD);
    check_val("hold_err_t2", 32'(hold_err), 0);
    hold_cyc(1'b0, 1'b1, 32'h80);
    check_comb("hold_t3", C_HOLD);
    check_val("hold_err_t3", 32'(hold_err), 1);
    hold_cyc(1'b0, 1'b1, 32'h80);
    check_comb("hold_t4_jump", c_jump(32'h80));
    check_val("hold_cnt", 32'(stall_cnt), 4);
    idle();
    idle();
    check_val("hold_err_sticky", 32'(hold_err), 1);

    // Reset while in HOLD
    hold_cyc(1'b1, 1'b0, 32'h0);
    hold_cyc(1'b1, 1'b0, 32'h0);
    check_comb("rst_hold_pre", C_HOLD);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h10, 1'b1);
    check_comb("rst_hold_cycle", C_IDLE);
    idle();
    check_comb("rst_hold_after", C_IDLE);
    check_val("rst_hold_cnt", 32'(stall_cnt), 0);
    check_val("rst_hold_err", 32'(hold_err), 0);

    // Long hold saturates the narrow stall counter
    for (int i = 0; i < 20; i++) hold_cyc(1'b1, 1'b0, 32'h0);
    idle();
    idle();
    check_comb("sat_idle", C_IDLE);
    check_val("sat_cnt", 32'(stall_cnt), (1 << CW) - 1);
    check_val("sat_err", 32'(hold_err), 1);

    // Randomized run against the reference model
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    m_flush_left = 0; m_holding = 0; m_hold_len = 0; m_err = 0; m_cnt = 0;
    hr_prev = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      logic r, h;
      r = ($urandom_range(0, 99) != 0);
      h = hr_prev ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      hr_prev = h;
      drive(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), $urandom, h);
      check_comb($sformatf("rand%0d", k), m_expect());
      check_val($sformatf("rand_cnt%0d", k), 32'(stall_cnt), 32'(m_cnt));
      check_val($sformatf("rand_err%0d", k), 32'(hold_err), 32'(m_err));
      m_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32I core. It detects load-use hazards between the instruction in decode and a load in execute, and redirects the PC on taken jumps/branches. It flushes the IF/ID and ID/EX registers, freezes the whole pipe on a multi-cycle hold request, and keeps a saturating stall-cycle counter.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles o_ifid_flush/o_idex_flush stay high after a jump (1..15)
HOLD_TIMEOUT, 1023, max consecutive HOLD cycles before o_hold_err is set
CNT_W, 16, width of o_stall_cnt

Ports:
i_clk  in  1  core clock, all state on rising edge
i_rst  in  1  synchronous reset, active-low (0 = reset)
i_id_rs1_addr  in  5  rs1 field of instruction in ID
i_id_rs2_addr  in  5  rs2 field of instruction in ID
i_id_rs1_used  in  1  ID instruction reads rs1
i_id_rs2_used  in  1  ID instruction reads rs2
i_ex_is_load  in  1  instruction in EX is a load
i_ex_rd_addr  in  5  destination of instruction in EX
i_ex_jump_en  in  1  EX resolved a taken jump/branch
i_ex_jump_addr  in  32  jump target
i_hold_req  in  1  multi-cycle unit requests pipeline freeze (level)
o_hold_ack  out  1  pipeline frozen (state HOLD)
o_pc_stall  out  1  PC keeps value
o_ifid_stall  out  1  IF/ID keeps value
o_idex_stall  out  1  ID/EX keeps value
o_exmem_stall  out  1  EX/MEM keeps value
o_ifid_flush  out  1  IF/ID loads NOP
o_idex_flush  out  1  ID/EX loads NOP (bubble)
o_pc_jump_en  out  1  PC loads o_pc_jump_addr
o_pc_jump_addr  out  32  redirect target
o_stall_cnt  out  CNT_W  cycles with o_pc_stall=1, saturating
o_hold_err  out  1  sticky hold-timeout flag

Behaviour:
- Reset (i_rst=0 at edge): state RUN, flush/hold counters 0, o_stall_cnt 0, o_hold_err 0. While i_rst=0 all combinational outputs forced 0 and o_pc_jump_addr=0.
- FSM states: RUN, FLUSH, HOLD (registered). Outputs Mealy, same cycle as inputs.
- load_use = i_ex_is_load & (i_ex_rd_addr!=0) & ((i_id_rs1_used & rs1==rd) | (i_id_rs2_used & rs2==rd)).
- RUN, priority jump > load_use:
  - i_ex_jump_en=1: o_pc_jump_en=1, o_pc_jump_addr=i_ex_jump_addr, o_ifid_flush=o_idex_flush=1, no stalls (even if load_use).
    - Next state FLUSH with fcnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1.
    - Else HOLD if i_hold_req, else RUN.
  - else load_use: o_pc_stall=o_ifid_stall=o_idex_flush=1 for this cycle only; hazard clears next cycle as the load advances.
  - else i_hold_req=1: next state HOLD. No effect this cycle (1-cycle entry latency).
- FLUSH: o_ifid_flush=o_idex_flush=1, fcnt decrements. i_ex_jump_en and load_use ignored (EX holds a bubble). Exit at fcnt==1 to HOLD if i_hold_req else RUN.
- HOLD:
  - o_hold_ack=1; o_pc_stall=o_ifid_stall=o_idex_stall=o_exmem_stall=1; jump, load_use and flush suppressed.
  - EX contents frozen, so a pending jump is taken the cycle after release.
  - Exit to RUN in the cycle after i_hold_req=0 is sampled. o_hold_ack drops together with stalls.
  - hcnt counts HOLD cycles (reset on entry). When hcnt reaches HOLD_TIMEOUT, o_hold_err<=1 (sticky until reset); HOLD continues.
- o_pc_jump_addr = i_ex_jump_addr whenever o_pc_jump_en=1, else 0.
- o_stall_cnt increments on every cycle with o_pc_stall=1; stops at 2^CNT_W-1 (no wrap).
- Reset mid-HOLD/FLUSH: immediate return to RUN, all outputs 0 on the reset cycle.

Decomposition:
- Shared defines file: state encodings (CTRL_RUN/CTRL_FLUSH/CTRL_HOLD), REG_ZERO=5'd0, NOP encoding reference.
- One sub-module, hazard_detect: purely combinational load_use compare, reused by the forwarding unit later.
- Counters and FSM stay in pipe_ctrl.

Test Plan:
- Load-use: ex_is_load=1, rd=5, rs1=5, rs1_used=1 for 1 cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle only; stall_cnt 0->1.
- rd=0 with rs1=0 used and ex_is_load=1 -> no stall; a load with rs2 match but rs2_used=0 -> no stall.
- Jump with FLUSH_CYCLES=2, addr=0x0000_0100 -> cycle T: jump_en=1, addr 0x100, both flushes; T+1: flushes only; T+2: all 0.
- Jump and load_use in the same cycle -> jump wins; no pc_stall; stall_cnt unchanged.
- hold_req high 3 cycles from T -> hold_ack and four stalls high T+1..T+3, low at T+4; stall_cnt +3. With HOLD_TIMEOUT=2, hold_err=1 from T+3 and still 1 after release.
- Assert i_rst=0 during HOLD -> next cycle all outputs 0, state RUN, stall_cnt 0, hold_err 0.
